// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD EX stage: instruction field positions,
// R3 opcode encodings, the R4 op-field layout and the saturating arithmetic helpers.
package simd_pkg;

    localparam int INSTR_W   = 25;
    localparam int DATA_W    = 128;

    localparam int FMT_BIT   = 24;
    localparam int SUBFMT_BIT = 23;
    localparam int LI_IDX_HI = 23;
    localparam int LI_IDX_LO = 21;
    localparam int LI_IMM_HI = 20;
    localparam int LI_IMM_LO = 5;
    localparam int R4_OP_HI  = 22;
    localparam int R4_OP_LO  = 20;
    localparam int R3_OP_HI  = 22;
    localparam int R3_OP_LO  = 15;

    typedef enum logic [7:0] {
        R3_NOP    = 8'h00,
        R3_A      = 8'h01,
        R3_AH     = 8'h02,
        R3_AHS    = 8'h03,
        R3_AND    = 8'h04,
        R3_BCW    = 8'h05,
        R3_CLZ    = 8'h06,
        R3_MAX    = 8'h07,
        R3_MIN    = 8'h08,
        R3_MSGN   = 8'h09,
        R3_MPYU   = 8'h0A,
        R3_OR     = 8'h0B,
        R3_POPCNT = 8'h0C,
        R3_ROT    = 8'h0D,
        R3_ROTW   = 8'h0E,
        R3_SHLHI  = 8'h0F,
        R3_SFH    = 8'h10,
        R3_SFW    = 8'h11,
        R3_SFHS   = 8'h12,
        R3_XOR    = 8'h13
    } r3_op_e;

    // R4 op field: MSB selects 64-bit lanes, middle bit subtracts, LSB picks the high half.
    typedef struct packed {
        logic is_long;
        logic is_sub;
        logic use_high;
    } r4_op_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15]) return s[16] ? 16'h8000 : 16'h7FFF;
        return s[15:0];
    endfunction

    function automatic logic [15:0] sat_sub16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} - {b[15], b};
        if (s[16] != s[15]) return s[16] ? 16'h8000 : 16'h7FFF;
        return s[15:0];
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} - {b[31], b};
        if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return s[31:0];
    endfunction

    function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {a[63], a} + {b[63], b};
        if (s[64] != s[63]) return s[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        return s[63:0];
    endfunction

    function automatic logic [63:0] sat_sub64(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {a[63], a} - {b[63], b};
        if (s[64] != s[63]) return s[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        return s[63:0];
    endfunction

    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        logic       hit;
        n   = '0;
        hit = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + 6'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [5:0] popcnt32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + {5'd0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/simd_alu_r3.sv
// Combinational R3 operation set: every per-lane result is built in parallel
// and the opcode picks one; unknown opcodes yield zero.
module simd_alu_r3
    import simd_pkg::*;
(
    input  logic [7:0]   opcode,
    input  logic [127:0] rs1,
    input  logic [127:0] rs2,
    output logic [127:0] result
);

    logic [127:0] add_w, clz_w, max_w, min_w, msgn_w, mpyu_w, popc_w, rotw_w, sf_w;
    logic [127:0] add_h, adds_h, shl_h, sf_h, sfs_h;
    logic [127:0] rot_all;
    logic [6:0]   rot_amt;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            logic [31:0] a, b;
            logic [4:0]  amt;
            assign a   = rs1[32*gi +: 32];
            assign b   = rs2[32*gi +: 32];
            assign amt = b[4:0];

            assign add_w[32*gi +: 32]  = a + b;
            assign sf_w[32*gi +: 32]   = b - a;
            assign clz_w[32*gi +: 32]  = {26'd0, clz32(a)};
            assign popc_w[32*gi +: 32] = {26'd0, popcnt32(a)};
            assign max_w[32*gi +: 32]  = ($signed(a) > $signed(b)) ? a : b;
            assign min_w[32*gi +: 32]  = ($signed(a) < $signed(b)) ? a : b;
            // Negating the most negative word saturates instead of wrapping back to itself.
            assign msgn_w[32*gi +: 32] = b[31] ? sat_sub32(32'd0, a) :
                                         (b == 32'd0) ? 32'd0 : a;
            assign mpyu_w[32*gi +: 32] = {16'd0, a[15:0]} * {16'd0, b[15:0]};
            assign rotw_w[32*gi +: 32] = (a >> amt) | (a << (6'd32 - {1'b0, amt}));
        end

        for (gi = 0; gi < 8; gi++) begin : g_half
            logic [15:0] a, b;
            assign a = rs1[16*gi +: 16];
            assign b = rs2[16*gi +: 16];

            assign add_h[16*gi +: 16]  = a + b;
            assign adds_h[16*gi +: 16] = sat_add16(a, b);
            assign sf_h[16*gi +: 16]   = b - a;
            assign sfs_h[16*gi +: 16]  = sat_sub16(b, a);
            assign shl_h[16*gi +: 16]  = a << b[3:0];
        end
    endgenerate

    assign rot_amt = rs2[6:0];
    // A shift by the full width yields zero, so a zero rotate amount needs no special case.
    assign rot_all = (rs1 >> rot_amt) | (rs1 << (8'd128 - {1'b0, rot_amt}));

    always_comb begin
        result = '0;
        case (opcode)
            R3_A:      result = add_w;
            R3_AH:     result = add_h;
            R3_AHS:    result = adds_h;
            R3_AND:    result = rs1 & rs2;
            R3_BCW:    result = {4{rs1[31:0]}};
            R3_CLZ:    result = clz_w;
            R3_MAX:    result = max_w;
            R3_MIN:    result = min_w;
            R3_MSGN:   result = msgn_w;
            R3_MPYU:   result = mpyu_w;
            R3_OR:     result = rs1 | rs2;
            R3_POPCNT: result = popc_w;
            R3_ROT:    result = rot_all;
            R3_ROTW:   result = rotw_w;
            R3_SHLHI:  result = shl_h;
            R3_SFH:    result = sf_h;
            R3_SFW:    result = sf_w;
            R3_SFHS:   result = sfs_h;
            R3_XOR:    result = rs1 ^ rs2;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/simd_execute.sv
// EX stage of the 128-bit SIMD pipeline: computes LI / R4 / R3 results
// combinationally and registers them with the instruction into EX/WB.
module simd_execute
    import simd_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [24:0]  instructionID,
    input  logic [127:0] rs1,
    input  logic [127:0] rs2,
    input  logic [127:0] rs3,
    input  logic         fowarded_data,
    output logic [127:0] ALUOut,
    output logic [24:0]  instructionWB
);

    logic [127:0] li_result;
    logic [127:0] r4_word_result;
    logic [127:0] r4_long_result;
    logic [127:0] r3_result;
    logic [127:0] alu_out_d, alu_out_q;
    logic [24:0]  instr_wb_d, instr_wb_q;
    logic [2:0]   li_index;
    logic [15:0]  li_imm;
    r4_op_t       r4_op;
    logic         unused_fwd;

    // Forwarding only matters upstream; the result is identical either way.
    assign unused_fwd = fowarded_data;

    assign li_index = instructionID[LI_IDX_HI:LI_IDX_LO];
    assign li_imm   = instructionID[LI_IMM_HI:LI_IMM_LO];
    assign r4_op    = r4_op_t'(instructionID[R4_OP_HI:R4_OP_LO]);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_li
            assign li_result[16*gi +: 16] = (li_index == 3'(gi)) ? li_imm : rs1[16*gi +: 16];
        end

        for (gi = 0; gi < 4; gi++) begin : g_r4_word
            logic [15:0] m3, m2;
            logic [31:0] prod, acc;
            assign m3   = r4_op.use_high ? rs3[32*gi+16 +: 16] : rs3[32*gi +: 16];
            assign m2   = r4_op.use_high ? rs2[32*gi+16 +: 16] : rs2[32*gi +: 16];
            assign acc  = rs1[32*gi +: 32];
            // Sign-extended operands make the truncated unsigned product equal the signed one.
            assign prod = {{16{m3[15]}}, m3} * {{16{m2[15]}}, m2};
            assign r4_word_result[32*gi +: 32] = r4_op.is_sub ? sat_sub32(acc, prod)
                                                               : sat_add32(acc, prod);
        end

        for (gi = 0; gi < 2; gi++) begin : g_r4_long
            logic [31:0] m3, m2;
            logic [63:0] prod, acc;
            assign m3   = r4_op.use_high ? rs3[64*gi+32 +: 32] : rs3[64*gi +: 32];
            assign m2   = r4_op.use_high ? rs2[64*gi+32 +: 32] : rs2[64*gi +: 32];
            assign acc  = rs1[64*gi +: 64];
            assign prod = {{32{m3[31]}}, m3} * {{32{m2[31]}}, m2};
            assign r4_long_result[64*gi +: 64] = r4_op.is_sub ? sat_sub64(acc, prod)
                                                               : sat_add64(acc, prod);
        end
    endgenerate

    simd_alu_r3 u_alu_r3 (
        .opcode (instructionID[R3_OP_HI:R3_OP_LO]),
        .rs1    (rs1),
        .rs2    (rs2),
        .result (r3_result)
    );

    always_comb begin
        alu_out_d  = '0;
        instr_wb_d = instructionID;
        if (!instructionID[FMT_BIT]) begin
            alu_out_d = li_result;
        end else if (instructionID[SUBFMT_BIT]) begin
            alu_out_d = r3_result;
        end else begin
            alu_out_d = r4_op.is_long ? r4_long_result : r4_word_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q  <= '0;
            instr_wb_q <= '0;
        end else begin
            alu_out_q  <= alu_out_d;
            instr_wb_q <= instr_wb_d;
        end
    end

    assign ALUOut        = alu_out_q;
    assign instructionWB = instr_wb_q;

endmodule

// File: tb/tb_simd_execute.sv
// Directed bench for simd_execute: each task applies hand-computed vectors
// and compares ALUOut / instructionWB one cycle later.
module tb_simd_execute;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [24:0]  instructionID = '0;
    logic [127:0] rs1 = '0;
    logic [127:0] rs2 = '0;
    logic [127:0] rs3 = '0;
    logic         fowarded_data = 1'b0;
    logic [127:0] ALUOut;
    logic [24:0]  instructionWB;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [24:0]  ins;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] c;
        logic [127:0] exp;
    } vec_t;

    simd_execute dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instructionID (instructionID),
        .rs1           (rs1),
        .rs2           (rs2),
        .rs3           (rs3),
        .fowarded_data (fowarded_data),
        .ALUOut        (ALUOut),
        .instructionWB (instructionWB)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] r3i(input logic [7:0] op);
        return {2'b11, op, 10'd0, 5'd3};
    endfunction

    function automatic logic [24:0] r4i(input logic [2:0] op);
        return {2'b10, op, 15'd0, 5'd4};
    endfunction

    function automatic logic [24:0] lii(input logic [2:0] idx, input logic [15:0] imm);
        return {1'b0, idx, imm, 5'd5};
    endfunction

    task automatic apply(input logic [24:0] ins, input logic [127:0] a,
                         input logic [127:0] b, input logic [127:0] c);
        @(negedge clk);
        instructionID = ins;
        rs1 = a;
        rs2 = b;
        rs3 = c;
        fowarded_data = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instructionID = r3i(8'h04);
        rs1 = '1;
        rs2 = 128'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0;
        @(posedge clk);
        #1;
        checks++;
        if (ALUOut !== 128'd0 || instructionWB !== 25'd0) begin
            errors++;
            $display("FAIL reset_hold: ALUOut=%h instructionWB=%h expected 0 / 0", ALUOut, instructionWB);
        end else $display("reset_hold ALUOut=%h instructionWB=%h", ALUOut, instructionWB);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ALUOut !== 128'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0 || instructionWB !== r3i(8'h04)) begin
            errors++;
            $display("FAIL reset_release: ALUOut=%h instructionWB=%h expected f0f0... / %h",
                     ALUOut, instructionWB, r3i(8'h04));
        end else $display("reset_release ALUOut=%h instructionWB=%h", ALUOut, instructionWB);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ALUOut !== 128'd0 || instructionWB !== 25'd0) begin
            errors++;
            $display("FAIL reset_async: ALUOut=%h instructionWB=%h expected 0 / 0", ALUOut, instructionWB);
        end else $display("reset_async ALUOut=%h instructionWB=%h", ALUOut, instructionWB);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ALUOut !== 128'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0 || instructionWB !== r3i(8'h04)) begin
            errors++;
            $display("FAIL reset_recover: ALUOut=%h instructionWB=%h", ALUOut, instructionWB);
        end else $display("reset_recover ALUOut=%h instructionWB=%h", ALUOut, instructionWB);
    endtask

    task automatic test_li();
        vec_t v[$];
        logic [127:0] base = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        v.push_back('{lii(3'd0, 16'hBEEF), base, '1, '1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_BEEF});
        v.push_back('{lii(3'd7, 16'hCAFE), base, '0, '1, 128'hCAFE_4567_89AB_CDEF_0011_2233_4455_6677});
        v.push_back('{lii(3'd3, 16'hA5A5), base, '1, '0, 128'h0123_4567_89AB_CDEF_A5A5_2233_4455_6677});
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i].ins, v[i].a, v[i].b, v[i].c);
            checks++;
            if (ALUOut !== v[i].exp || instructionWB !== v[i].ins) begin
                errors++;
                $display("FAIL li[%0d]: ALUOut=%h instructionWB=%h expected %h / %h",
                         i, ALUOut, instructionWB, v[i].exp, v[i].ins);
            end else $display("li[%0d] ALUOut=%h", i, ALUOut);
        end
    endtask

    task automatic test_r4();
        vec_t v[$];
        logic [127:0] wa = {32'h0, 32'h8000_0000, 32'd10, 32'h7FFF_FFF0};
        logic [127:0] w3 = {32'h0, 32'h0000_0002, 32'h0005_FFFE, 32'h0000_0100};
        logic [127:0] w2 = {32'h0, 32'h0000_0003, 32'h0007_0003, 32'h0000_0100};
        logic [127:0] la = {64'h64, 64'h7FFF_FFFF_FFFF_FFFF};
        logic [127:0] l3 = {32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h2};
        logic [127:0] l2 = {32'h0, 32'h8000_0000, 32'h5, 32'h3};
        v.push_back('{r4i(3'b000), wa, w2, w3, {32'h0, 32'h8000_0006, 32'h0000_0004, 32'h7FFF_FFFF}});
        v.push_back('{r4i(3'b001), wa, w2, w3, {32'h0, 32'h8000_0000, 32'h0000_002D, 32'h7FFF_FFF0}});
        v.push_back('{r4i(3'b010), wa, w2, w3, {32'h0, 32'h8000_0000, 32'h0000_0010, 32'h7FFE_FFF0}});
        v.push_back('{r4i(3'b011), wa, w2, w3, {32'h0, 32'h8000_0000, 32'hFFFF_FFE7, 32'h7FFF_FFF0}});
        v.push_back('{r4i(3'b100), la, l2, l3, {64'h4000_0000_0000_0064, 64'h7FFF_FFFF_FFFF_FFFF}});
        v.push_back('{r4i(3'b101), la, l2, l3, {64'h64, 64'h7FFF_FFFF_FFFF_FFFA}});
        v.push_back('{r4i(3'b110), la, l2, l3, {64'hC000_0000_0000_0064, 64'h7FFF_FFFF_FFFF_FFF9}});
        v.push_back('{r4i(3'b111), la, l2, l3, {64'h64, 64'h7FFF_FFFF_FFFF_FFFF}});
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i].ins, v[i].a, v[i].b, v[i].c);
            checks++;
            if (ALUOut !== v[i].exp || instructionWB !== v[i].ins) begin
                errors++;
                $display("FAIL r4[%0d]: ALUOut=%h instructionWB=%h expected %h / %h",
                         i, ALUOut, instructionWB, v[i].exp, v[i].ins);
            end else $display("r4[%0d] ALUOut=%h", i, ALUOut);
        end
    endtask

    task automatic test_halfword();
        vec_t v[$];
        logic [127:0] a1 = {16'h7FFF, 16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1};
        logic [127:0] b1 = {16'h8, 16'hF, 16'hF, 16'hF, 16'hF, 16'hF, 16'hF, 16'hF};
        logic [127:0] a2 = {16'h8001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'hFFFF};
        logic [127:0] b2 = {16'h0008, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'hFFFE};
        logic [127:0] s1 = {16'h8001, {7{16'h8001}}};
        logic [127:0] t1 = {16'h00F7, 16'h00F6, 16'h00F5, 16'h00F4, 16'h00F3, 16'h00F2, 16'h00F1, 16'h00F0};
        v.push_back('{r3i(8'h03), a1, b1, '0, {16'h7FFF, 16'h16, 16'h15, 16'h14, 16'h13, 16'h12, 16'h11, 16'h10}});
        v.push_back('{r3i(8'h02), a1, b1, '0, {16'h8007, 16'h16, 16'h15, 16'h14, 16'h13, 16'h12, 16'h11, 16'h10}});
        v.push_back('{r3i(8'h03), 128'h8000, 128'hFFFF, '0, 128'h8000});
        v.push_back('{r3i(8'h02), 128'h8000, 128'hFFFF, '0, 128'h7FFF});
        v.push_back('{r3i(8'h12), a2, b2, '0, {16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'hFFFF}});
        v.push_back('{r3i(8'h10), a2, b2, '0, {16'h8007, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'hFFFF}});
        v.push_back('{r3i(8'h0F), s1, t1, '0, {16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h8001}});
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i].ins, v[i].a, v[i].b, v[i].c);
            checks++;
            if (ALUOut !== v[i].exp || instructionWB !== v[i].ins) begin
                errors++;
                $display("FAIL halfword[%0d]: ALUOut=%h instructionWB=%h expected %h / %h",
                         i, ALUOut, instructionWB, v[i].exp, v[i].ins);
            end else $display("halfword[%0d] ALUOut=%h", i, ALUOut);
        end
    endtask

    task automatic test_word();
        vec_t v[$];
        logic [127:0] ma = {32'd100, 32'd100, 32'h0, 32'h8000_0000};
        logic [127:0] mb = {32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
        logic [127:0] aa = {32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'd10};
        logic [127:0] ab = {32'd1, 32'd1, 32'd2, 32'd20};
        logic [127:0] xa = {32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd7};
        logic [127:0] xb = {32'd1, 32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'd7};
        v.push_back('{r3i(8'h09), ma, mb, '0, {32'd100, 32'hFFFF_FF9C, 32'h0, 32'h0}});
        v.push_back('{r3i(8'h09), 128'h8000_0000, 128'hFFFF_FFFF, '0, 128'h7FFF_FFFF});
        v.push_back('{r3i(8'h01), aa, ab, '0, {32'h0, 32'h8000_0000, 32'd3, 32'd30}});
        v.push_back('{r3i(8'h11), aa, ab, '0, {32'd2, 32'h8000_0002, 32'd1, 32'd10}});
        v.push_back('{r3i(8'h07), xa, xb, '0, {32'd1, 32'd5, 32'h7FFF_FFFF, 32'd7}});
        v.push_back('{r3i(8'h08), xa, xb, '0, {32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd7}});
        v.push_back('{r3i(8'h0A), {64'h0, 32'd3, 32'hFFFF_9C40}, {64'h0, 32'd5, 32'h1234_9C40}, '0,
                     {64'h0, 32'd15, 32'h5F5E_1000}});
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i].ins, v[i].a, v[i].b, v[i].c);
            checks++;
            if (ALUOut !== v[i].exp || instructionWB !== v[i].ins) begin
                errors++;
                $display("FAIL word[%0d]: ALUOut=%h instructionWB=%h expected %h / %h",
                         i, ALUOut, instructionWB, v[i].exp, v[i].ins);
            end else $display("word[%0d] ALUOut=%h", i, ALUOut);
        end
    endtask

    task automatic test_bits();
        vec_t v[$];
        logic [127:0] ca = {32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0FFF_FFFE};
        logic [127:0] la = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        logic [127:0] lb = 128'h00FF_F0F0_0F0F_FF00_FFFF_0000_AAAA_5555;
        v.push_back('{r3i(8'h06), ca, '1, '0, {32'd32, 32'd0, 32'd31, 32'd4}});
        v.push_back('{r3i(8'h0C), ca, '1, '0, {32'd0, 32'd32, 32'd1, 32'd27}});
        v.push_back('{r3i(8'h0C), 128'h0003_0001, '0, '0, 128'd3});
        v.push_back('{r3i(8'h05), {32'h1234_5678, 32'h9ABC_DEF0, 32'h1, 32'hFFFF_FFFE}, '0, '0, {4{32'hFFFF_FFFE}}});
        v.push_back('{r3i(8'h04), la, lb, '0, 128'h0023_4060_090B_CD00_0011_0000_0000_4455});
        v.push_back('{r3i(8'h0B), la, lb, '0, 128'h01FF_F5F7_8FAF_FFEF_FFFF_2233_EEFF_7777});
        v.push_back('{r3i(8'h13), la, lb, '0, 128'h01DC_B597_86A4_32EF_FFEE_2233_EEFF_3322});
        v.push_back('{r3i(8'h00), la, lb, '1, 128'h0});
        v.push_back('{r3i(8'h14), la, lb, '1, 128'h0});
        v.push_back('{r3i(8'hFF), la, lb, '1, 128'h0});
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i].ins, v[i].a, v[i].b, v[i].c);
            checks++;
            if (ALUOut !== v[i].exp || instructionWB !== v[i].ins) begin
                errors++;
                $display("FAIL bits[%0d]: ALUOut=%h instructionWB=%h expected %h / %h",
                         i, ALUOut, instructionWB, v[i].exp, v[i].ins);
            end else $display("bits[%0d] ALUOut=%h", i, ALUOut);
        end
    endtask

    task automatic test_rotate();
        vec_t v[$];
        v.push_back('{r3i(8'h0D), 128'hF, 128'h181, '0, 128'h8000_0000_0000_0000_0000_0000_0000_0007});
        v.push_back('{r3i(8'h0D), {64'hA, 64'hB}, 128'h40, '0, {64'hB, 64'hA}});
        v.push_back('{r3i(8'h0D), 128'h1234, 128'h0, '0, 128'h1234});
        v.push_back('{r3i(8'h0E), {4{32'hF}}, {32'd4, 32'd3, 32'd2, 32'h21}, '0,
                     {32'hF000_0000, 32'hE000_0001, 32'hC000_0003, 32'h8000_0007}});
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i].ins, v[i].a, v[i].b, v[i].c);
            checks++;
            if (ALUOut !== v[i].exp || instructionWB !== v[i].ins) begin
                errors++;
                $display("FAIL rotate[%0d]: ALUOut=%h instructionWB=%h expected %h / %h",
                         i, ALUOut, instructionWB, v[i].exp, v[i].ins);
            end else $display("rotate[%0d] ALUOut=%h", i, ALUOut);
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        v.push_back('{lii(3'd1, 16'h5A5A), '0, '0, '0, 128'h5A5A_0000});
        v.push_back('{r3i(8'h01), 128'h1, 128'h2, '0, 128'h3});
        v.push_back('{r4i(3'b000), 128'h0, 128'h2, 128'h3, 128'h6});
        v.push_back('{r3i(8'h00), '1, '1, '1, 128'h0});
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i].ins, v[i].a, v[i].b, v[i].c);
            checks++;
            if (ALUOut !== v[i].exp || instructionWB !== v[i].ins) begin
                errors++;
                $display("FAIL b2b[%0d]: ALUOut=%h instructionWB=%h expected %h / %h",
                         i, ALUOut, instructionWB, v[i].exp, v[i].ins);
            end else $display("b2b[%0d] ALUOut=%h instructionWB=%h", i, ALUOut, instructionWB);
        end
    endtask

    initial begin
        test_reset();
        test_li();
        test_r4();
        test_halfword();
        test_word();
        test_bits();
        test_rotate();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
